// File: rtl/display_pkg.sv
// Shared types, constants and the round-robin search for the display scheduler.
package display_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHOW  = 2'd1,
        BLANK = 2'd2
    } disp_state_t;

    localparam logic [6:0] SEG_OFF    = 7'h7F;
    localparam int unsigned MAX_DIGITS = 32;

    // First set bit of mask strictly after cur, wrapping; returns cur if it is the only one.
    function automatic int unsigned next_idx(input logic [MAX_DIGITS-1:0] mask,
                                             input int unsigned cur,
                                             input int unsigned n);
        int unsigned res;
        int unsigned j;
        logic        found;
        res   = cur;
        found = 1'b0;
        for (int unsigned i = 1; i <= MAX_DIGITS; i++) begin
            j = (cur + i) % n;
            if (!found && (i <= n) && mask[j[4:0]]) begin
                res   = j;
                found = 1'b1;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/seg7_decoder.sv
// Combinational hex nibble to active-low seven-segment pattern {g,f,e,d,c,b,a}.
module seg7_decoder
    import display_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_OFF;
        unique case (nibble)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            4'hF: seg = 7'h0E;
            default: seg = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/display_scheduler.sv
// Round-robin seven-segment multiplexer with a slot-counter timebase.
// Define DISPLAY_BLANK_EN to insert BLANK_CYCLES dark cycles between slots.
module display_scheduler
    import display_pkg::*;
#(
    parameter int unsigned N_DIGITS     = 2,
    parameter int unsigned DIV_COUNT    = 100_000,
    parameter int unsigned BLANK_CYCLES = 1_000
) (
    input  logic                                               clk,
    input  logic                                               reset,
    input  logic                                               enable,
    input  logic [N_DIGITS-1:0]                                digit_en,
    input  logic [4*N_DIGITS-1:0]                              digits,
    output logic [N_DIGITS-1:0]                                digit_sel,
    output logic [6:0]                                         seg,
    output logic [((N_DIGITS > 1) ? $clog2(N_DIGITS) : 1)-1:0] cur_idx,
    output logic                                               slot_tick
);

    localparam int unsigned IDX_W   = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int unsigned CNT_MAX = (DIV_COUNT > BLANK_CYCLES) ? DIV_COUNT : BLANK_CYCLES;
    localparam int unsigned CNT_W   = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV_COUNT - 1);
`ifdef DISPLAY_BLANK_EN
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
`endif

    disp_state_t         state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [3:0]          nib_q, nib_d;
    logic [N_DIGITS-1:0] digit_sel_q, digit_sel_d;
    logic [6:0]          seg_q, seg_d;
    logic [IDX_W-1:0]    cur_idx_q, cur_idx_d;
    logic                slot_tick_q, slot_tick_d;

    logic [IDX_W-1:0]    first_idx, nxt_idx;
    logic [6:0]          seg_dec;
    logic                show;

    seg7_decoder u_dec (
        .nibble (nib_q),
        .seg    (seg_dec)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        nib_d     = nib_q;
        first_idx = IDX_W'(next_idx(MAX_DIGITS'(digit_en), N_DIGITS - 1, N_DIGITS));
        nxt_idx   = IDX_W'(next_idx(MAX_DIGITS'(digit_en), 32'(idx_q), N_DIGITS));

        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (digit_en != '0) begin
                    state_d = SHOW;
                    idx_d   = first_idx;
                    nib_d   = digits[{first_idx, 2'b00} +: 4];
                end
            end
            SHOW: begin
                if (cnt_q == DIV_LAST) begin
                    cnt_d = '0;
                    if (digit_en == '0) begin
                        state_d = IDLE;
                    end else begin
                        idx_d = nxt_idx;
`ifdef DISPLAY_BLANK_EN
                        state_d = BLANK;
`else
                        state_d = SHOW;
                        nib_d   = digits[{nxt_idx, 2'b00} +: 4];
`endif
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`ifdef DISPLAY_BLANK_EN
            BLANK: begin
                if (cnt_q == BLANK_LAST) begin
                    cnt_d = '0;
                    if (digit_en == '0) begin
                        state_d = IDLE;
                    end else begin
                        state_d = SHOW;
                        nib_d   = digits[{idx_q, 2'b00} +: 4];
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`endif
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        if (!enable) begin
            state_d = IDLE;
            cnt_d   = '0;
        end

        // Outputs trail the state by one edge; enable gates them so a drop darkens at once.
        show        = enable && (state_q == SHOW);
        digit_sel_d = show ? (N_DIGITS'(1) << idx_q) : '0;
        seg_d       = show ? seg_dec : SEG_OFF;
        cur_idx_d   = show ? idx_q : cur_idx_q;
        slot_tick_d = show && (cnt_q == DIV_LAST);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            nib_q       <= '0;
            digit_sel_q <= '0;
            seg_q       <= SEG_OFF;
            cur_idx_q   <= '0;
            slot_tick_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            nib_q       <= nib_d;
            digit_sel_q <= digit_sel_d;
            seg_q       <= seg_d;
            cur_idx_q   <= cur_idx_d;
            slot_tick_q <= slot_tick_d;
        end
    end

    assign digit_sel = digit_sel_q;
    assign seg       = seg_q;
    assign cur_idx   = cur_idx_q;
    assign slot_tick = slot_tick_q;

endmodule

// File: tb/tb_display_scheduler.sv
// Scoreboard bench for display_scheduler (N_DIGITS=2, DIV_COUNT=4, BLANK_CYCLES=2).
module tb_display_scheduler;

    localparam int DIV = 4;
`ifdef DISPLAY_BLANK_EN
    localparam int GAP = 2;
`else
    localparam int GAP = 0;
`endif

    logic       clk = 1'b0;
    logic       reset, enable;
    logic [1:0] digit_en;
    logic [7:0] digits;
    logic [1:0] digit_sel;
    logic [6:0] seg;
    logic [0:0] cur_idx;
    logic       slot_tick;

    always #5 clk = ~clk;

    display_scheduler #(
        .N_DIGITS     (2),
        .DIV_COUNT    (DIV),
        .BLANK_CYCLES (2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .digit_en  (digit_en),
        .digits    (digits),
        .digit_sel (digit_sel),
        .seg       (seg),
        .cur_idx   (cur_idx),
        .slot_tick (slot_tick)
    );

    typedef struct packed {
        logic [1:0] sel;
        logic [6:0] seg;
        logic       idx;
        logic       idx_care;
        logic       tick;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    function automatic logic [6:0] seg_of(input logic [3:0] v);
        case (v)
            4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
            4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
            4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
            4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
        endcase
    endfunction

    task automatic push_dark(input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e = '{sel: 2'b00, seg: 7'h7F, idx: 1'b0, idx_care: 1'b0, tick: 1'b0};
            sb.push_back(e);
        end
    endtask

    task automatic push_lit(input int d, input logic [3:0] nib, input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.sel      = (d == 0) ? 2'b01 : 2'b10;
            e.seg      = seg_of(nib);
            e.idx      = 1'(d);
            e.idx_care = 1'b1;
            e.tick     = (i == DIV - 1);
            sb.push_back(e);
        end
    endtask

    task automatic go_idle();
        enable = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        exp_t e;
        int   k;
        reset = 1'b0; enable = 1'b0; digit_en = 2'b00; digits = 8'h00;
        #1 reset = 1'b1;
        #1;
        checks++;
        if ({digit_sel, seg, cur_idx, slot_tick} !== {2'b00, 7'h7F, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_init got sel=%b seg=%h idx=%0d tick=%b want 00/7f/0/0",
                     digit_sel, seg, cur_idx, slot_tick);
        end
        @(negedge clk) reset = 1'b0;
        digit_en = 2'b11; digits = 8'h3A; enable = 1'b1;
        push_dark(1); push_lit(0, 4'hA, DIV); push_dark(GAP); push_lit(1, 4'h3, 2);
        k = 0;
        while (sb.size() > 0) begin
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if ({digit_sel, seg, slot_tick} !== {e.sel, e.seg, e.tick} ||
                (e.idx_care && cur_idx !== e.idx)) begin
                errors++;
                $display("FAIL reset_run[%0d] got sel=%b seg=%h idx=%0d tick=%b want sel=%b seg=%h idx=%0d tick=%b",
                         k, digit_sel, seg, cur_idx, slot_tick, e.sel, e.seg, e.idx, e.tick);
            end
            k++;
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({digit_sel, seg, cur_idx, slot_tick} !== {2'b00, 7'h7F, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_async got sel=%b seg=%h idx=%0d tick=%b want 00/7f/0/0",
                     digit_sel, seg, cur_idx, slot_tick);
        end
        @(negedge clk) reset = 1'b0;
        push_dark(1); push_lit(0, 4'hA, DIV);
        k = 0;
        while (sb.size() > 0) begin
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if ({digit_sel, seg, slot_tick} !== {e.sel, e.seg, e.tick} ||
                (e.idx_care && cur_idx !== e.idx)) begin
                errors++;
                $display("FAIL reset_restart[%0d] got sel=%b seg=%h idx=%0d tick=%b want sel=%b seg=%h idx=%0d tick=%b",
                         k, digit_sel, seg, cur_idx, slot_tick, e.sel, e.seg, e.idx, e.tick);
            end
            k++;
        end
    endtask

    task automatic test_rotation();
        exp_t e;
        int   k;
        go_idle();
        digit_en = 2'b11; digits = 8'h3A; enable = 1'b1;
        push_dark(1);
        for (int r = 0; r < 2; r++) begin
            push_lit(0, 4'hA, DIV); push_dark(GAP); push_lit(1, 4'h3, DIV); push_dark(GAP);
        end
        k = 0;
        while (sb.size() > 0) begin
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if ({digit_sel, seg, slot_tick} !== {e.sel, e.seg, e.tick} ||
                (e.idx_care && cur_idx !== e.idx)) begin
                errors++;
                $display("FAIL rotation[%0d] got sel=%b seg=%h idx=%0d tick=%b want sel=%b seg=%h idx=%0d tick=%b",
                         k, digit_sel, seg, cur_idx, slot_tick, e.sel, e.seg, e.idx, e.tick);
            end
            k++;
        end
    endtask

    task automatic test_single_digit();
        exp_t e;
        int   k;
        go_idle();
        digit_en = 2'b10; digits = 8'h50; enable = 1'b1;
        push_dark(1);
        for (int r = 0; r < 3; r++) begin
            push_lit(1, 4'h5, DIV); push_dark(GAP);
        end
        k = 0;
        while (sb.size() > 0) begin
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if ({digit_sel, seg, slot_tick} !== {e.sel, e.seg, e.tick} ||
                (e.idx_care && cur_idx !== e.idx)) begin
                errors++;
                $display("FAIL single_digit[%0d] got sel=%b seg=%h idx=%0d tick=%b want sel=%b seg=%h idx=%0d tick=%b",
                         k, digit_sel, seg, cur_idx, slot_tick, e.sel, e.seg, e.idx, e.tick);
            end
            k++;
        end
    endtask

    task automatic test_mask_off();
        exp_t e;
        int   k;
        go_idle();
        digit_en = 2'b11; digits = 8'h3A; enable = 1'b1;
        push_dark(1); push_lit(0, 4'hA, DIV); push_dark(6);
        k = 0;
        while (sb.size() > 0) begin
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if ({digit_sel, seg, slot_tick} !== {e.sel, e.seg, e.tick} ||
                (e.idx_care && cur_idx !== e.idx)) begin
                errors++;
                $display("FAIL mask_off[%0d] got sel=%b seg=%h idx=%0d tick=%b want sel=%b seg=%h idx=%0d tick=%b",
                         k, digit_sel, seg, cur_idx, slot_tick, e.sel, e.seg, e.idx, e.tick);
            end
            if (k == 2) digit_en = 2'b00;
            k++;
        end
    endtask

    task automatic test_enable_drop();
        exp_t e;
        int   k;
        go_idle();
        digit_en = 2'b11; digits = 8'h3A; enable = 1'b1;
        push_dark(1); push_lit(0, 4'hA, 2); push_dark(4); push_lit(0, 4'hA, DIV);
        k = 0;
        while (sb.size() > 0) begin
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if ({digit_sel, seg, slot_tick} !== {e.sel, e.seg, e.tick} ||
                (e.idx_care && cur_idx !== e.idx)) begin
                errors++;
                $display("FAIL enable_drop[%0d] got sel=%b seg=%h idx=%0d tick=%b want sel=%b seg=%h idx=%0d tick=%b",
                         k, digit_sel, seg, cur_idx, slot_tick, e.sel, e.seg, e.idx, e.tick);
            end
            if (k == 2) enable = 1'b0;
            if (k == 5) enable = 1'b1;
            k++;
        end
    endtask

    task automatic test_latch();
        exp_t e;
        int   k;
        go_idle();
        digit_en = 2'b01; digits = 8'h07; enable = 1'b1;
        push_dark(1); push_lit(0, 4'h7, DIV); push_dark(GAP); push_lit(0, 4'h0, DIV);
        k = 0;
        while (sb.size() > 0) begin
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if ({digit_sel, seg, slot_tick} !== {e.sel, e.seg, e.tick} ||
                (e.idx_care && cur_idx !== e.idx)) begin
                errors++;
                $display("FAIL latch[%0d] got sel=%b seg=%h idx=%0d tick=%b want sel=%b seg=%h idx=%0d tick=%b",
                         k, digit_sel, seg, cur_idx, slot_tick, e.sel, e.seg, e.idx, e.tick);
            end
            if (k == 2) digits = 8'h00;
            k++;
        end
    endtask

    task automatic test_decode();
        exp_t e;
        for (int v = 0; v < 16; v++) begin
            go_idle();
            digit_en = 2'b01; digits = {4'h0, 4'(v)}; enable = 1'b1;
            push_dark(1); push_lit(0, 4'(v), DIV);
            while (sb.size() > 0) begin
                @(negedge clk);
                e = sb.pop_front();
                checks++;
                if ({digit_sel, seg, slot_tick} !== {e.sel, e.seg, e.tick} ||
                    (e.idx_care && cur_idx !== e.idx)) begin
                    errors++;
                    $display("FAIL decode[%h] got sel=%b seg=%h idx=%0d tick=%b want sel=%b seg=%h idx=%0d tick=%b",
                             v, digit_sel, seg, cur_idx, slot_tick, e.sel, e.seg, e.idx, e.tick);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_rotation();
        test_single_digit();
        test_mask_off();
        test_enable_drop();
        test_latch();
        test_decode();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
